// File: rtl/ps2_keyboard_rx_if.sv
// CPU-side bus of the PS/2 keyboard receiver: FWFT FIFO read port plus error status.
// master = receiver, slave = CPU.
interface ps2_keyboard_rx_if #(
  parameter int unsigned FIFO_DEPTH = 8
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic          rd_en;
  logic          err_clear;
  logic [9:0]    rd_data;
  logic          rd_valid;
  logic [CW-1:0] fifo_count;
  logic          frame_error;
  logic          overflow;

  modport master (
    input  rd_en, err_clear,
    output rd_data, rd_valid, fifo_count, frame_error, overflow
  );

  modport slave (
    output rd_en, err_clear,
    input  rd_data, rd_valid, fifo_count, frame_error, overflow
  );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronises the PS/2 pins into CLK_CPU, deframes 11-bit frames,
// folds E0/F0 prefixes into flags and queues {ext, brk, code} in a first-word-fall-through FIFO.
module ps2_keyboard_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 32000,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic              CLK_CPU,
  input  logic              reset,
  input  logic              keyboard_clock,
  input  logic              keyboard_data,
  ps2_keyboard_rx_if.master cpu
);
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_prev;
  logic                   fall;
  logic                   ps2_dat;

  state_t                 state, state_d;
  logic [2:0]             bitcnt;
  logic [7:0]             shreg;
  logic                   par_bit;
  logic [TCW-1:0]         tcnt;

  logic                   start, shift_en, par_en;
  logic                   frame_ok, frame_bad, abort, flag_clr, timeout_hit;

  logic                   byte_vld;
  logic                   ext, brk;
  logic                   push, pop, full, empty, push_ok, ovf_set;

  logic [9:0]             mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count;
  logic                   frame_error_q, overflow_q;

  // Input synchronisers preset to the idle (released) bus level.
  always_ff @(posedge CLK_CPU) begin
    if (!reset) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], keyboard_clock};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], keyboard_data};
      clk_prev <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fall    = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign ps2_dat = dat_sync[SYNC_STAGES-1];

  always_ff @(posedge CLK_CPU) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Timeout fires TIMEOUT_CYCLES clocks after the last falling edge was registered.
  assign timeout_hit = (state != S_IDLE) && !fall && (tcnt == TCW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d   = state;
    start     = 1'b0;
    shift_en  = 1'b0;
    par_en    = 1'b0;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    abort     = 1'b0;
    flag_clr  = 1'b0;
    if (timeout_hit) begin
      state_d  = S_IDLE;
      abort    = 1'b1;
      flag_clr = 1'b1;
    end else if (fall) begin
      unique case (state)
        S_IDLE: begin
          if (!ps2_dat) begin
            state_d = S_DATA;
            start   = 1'b1;
          end else begin
            frame_bad = 1'b1;
          end
        end
        S_DATA: begin
          shift_en = 1'b1;
          if (bitcnt == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_en  = 1'b1;
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (ps2_dat && (^{shreg, par_bit})) begin
            frame_ok = 1'b1;
          end else begin
            frame_bad = 1'b1;
            flag_clr  = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_CPU) begin
    if (!reset) begin
      bitcnt        <= '0;
      shreg         <= '0;
      par_bit       <= 1'b0;
      tcnt          <= '0;
      byte_vld      <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      if (start) begin
        bitcnt <= '0;
      end else if (shift_en) begin
        bitcnt <= bitcnt + 3'd1;
      end
      if (shift_en) shreg <= {ps2_dat, shreg[7:1]};
      if (par_en) par_bit <= ps2_dat;
      if ((state == S_IDLE) || fall) begin
        tcnt <= '0;
      end else begin
        tcnt <= tcnt + TCW'(1);
      end
      byte_vld      <= frame_ok;
      frame_error_q <= frame_bad | abort;
    end
  end

  // shreg is stable during the processing cycle: it only shifts in DATA.
  assign push = byte_vld && (shreg != 8'hE0) && (shreg != 8'hF0);

  always_ff @(posedge CLK_CPU) begin
    if (!reset) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (flag_clr) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (byte_vld) begin
      if (shreg == 8'hE0) begin
        ext <= 1'b1;
      end else if (shreg == 8'hF0) begin
        brk <= 1'b1;
      end else begin
        ext <= 1'b0;
        brk <= 1'b0;
      end
    end
  end

  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign pop     = cpu.rd_en && !empty;
  assign push_ok = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  always_ff @(posedge CLK_CPU) begin
    if (push_ok) mem[wr_ptr] <= {ext, brk, shreg};
  end

  always_ff @(posedge CLK_CPU) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      unique case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (ovf_set) begin
        overflow_q <= 1'b1;
      end else if (cpu.err_clear) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign cpu.rd_data     = empty ? '0 : mem[rd_ptr];
  assign cpu.rd_valid    = !empty;
  assign cpu.fifo_count  = count;
  assign cpu.frame_error = frame_error_q;
  assign cpu.overflow    = overflow_q;
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: PS/2 frames driven bit by bit, results checked with immediate assertions.
module tb_ps2_keyboard_rx;
  localparam int unsigned T    = 500;
  localparam int unsigned HALF = 40;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic kb_clk = 1'b1;
  logic kb_dat = 1'b1;
  int   ncmp   = 0;
  int   nfail  = 0;

  ps2_keyboard_rx_if #(.FIFO_DEPTH(8)) bus ();

  ps2_keyboard_rx #(
    .TIMEOUT_CYCLES(T),
    .FIFO_DEPTH(8),
    .SYNC_STAGES(2)
  ) dut (
    .CLK_CPU(clk),
    .reset(rst_n),
    .keyboard_clock(kb_clk),
    .keyboard_data(kb_dat),
    .cpu(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] b, input logic bad_par);
    return {1'b1, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  // Drives n bits; returns at a negedge right after the last clock fall, clock left low.
  task automatic ps2_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      kb_dat = f[i];
      repeat (HALF) @(negedge clk);
      kb_clk = 1'b0;
      if (i != n - 1) begin
        repeat (HALF) @(negedge clk);
        kb_clk = 1'b1;
      end
    end
  endtask

  task automatic ps2_release();
    repeat (HALF) @(negedge clk);
    kb_clk = 1'b1;
    kb_dat = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par);
    ps2_bits(frame_of(b, bad_par), 11);
    ps2_release();
  endtask

  task automatic pop_check(input string tag, input logic [9:0] exp);
    chk({tag, "_valid"}, 16'(bus.rd_valid), 16'h1);
    chk(tag, 16'(bus.rd_data), 16'(exp));
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  initial begin
    int fe_seen;
    logic [10:0] idle_bit;
    bus.rd_en     = 1'b0;
    bus.err_clear = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_valid", 16'(bus.rd_valid), 16'h0);
    chk("rst_data", 16'(bus.rd_data), 16'h0);
    chk("rst_count", 16'(bus.fifo_count), 16'h0);
    chk("rst_ferr", 16'(bus.frame_error), 16'h0);
    chk("rst_ovf", 16'(bus.overflow), 16'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 1: make code latency and single pop
    ps2_bits(frame_of(8'h1C, 1'b0), 11);
    repeat (3) @(negedge clk);
    chk("t1_valid_early", 16'(bus.rd_valid), 16'h0);
    @(negedge clk);
    chk("t1_valid", 16'(bus.rd_valid), 16'h1);
    chk("t1_data", 16'(bus.rd_data), 16'h01C);
    chk("t1_count", 16'(bus.fifo_count), 16'h1);
    ps2_release();
    pop_check("t1_pop", 10'h01C);
    chk("t1_empty", 16'(bus.rd_valid), 16'h0);

    // 2: prefix folding
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
    send_byte(8'hE0, 1'b0);
    send_byte(8'h74, 1'b0);
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h74, 1'b0);
    chk("t2_count", 16'(bus.fifo_count), 16'h3);
    pop_check("t2_a", 10'h11C);
    pop_check("t2_b", 10'h274);
    pop_check("t2_c", 10'h374);
    chk("t2_empty", 16'(bus.rd_valid), 16'h0);

    // 3: parity error pulse, flag clearing, spurious start bit
    ps2_bits(frame_of(8'h1C, 1'b1), 11);
    repeat (2) @(negedge clk);
    chk("t3_ferr_pre", 16'(bus.frame_error), 16'h0);
    @(negedge clk);
    chk("t3_ferr", 16'(bus.frame_error), 16'h1);
    @(negedge clk);
    chk("t3_ferr_post", 16'(bus.frame_error), 16'h0);
    ps2_release();
    chk("t3_count", 16'(bus.fifo_count), 16'h0);
    send_byte(8'hE0, 1'b0);
    send_byte(8'h1C, 1'b1);
    send_byte(8'h74, 1'b0);
    pop_check("t3_ext_cleared", 10'h074);
    idle_bit = 11'h7FF;
    ps2_bits(idle_bit, 1);
    repeat (2) @(negedge clk);
    chk("t3_start1_pre", 16'(bus.frame_error), 16'h0);
    @(negedge clk);
    chk("t3_start1", 16'(bus.frame_error), 16'h1);
    ps2_release();
    chk("t3_start1_count", 16'(bus.fifo_count), 16'h0);

    // 4: timeout after five bits
    ps2_bits(frame_of(8'h55, 1'b0), 5);
    repeat (T + 2) @(negedge clk);
    chk("t4_ferr_pre", 16'(bus.frame_error), 16'h0);
    @(negedge clk);
    chk("t4_ferr", 16'(bus.frame_error), 16'h1);
    @(negedge clk);
    chk("t4_ferr_post", 16'(bus.frame_error), 16'h0);
    ps2_release();
    send_byte(8'h29, 1'b0);
    pop_check("t4_after", 10'h029);

    // 5: overflow, err_clear, push+pop while full
    for (int i = 1; i <= 9; i++) send_byte(8'(i), 1'b0);
    chk("t5_count", 16'(bus.fifo_count), 16'h8);
    chk("t5_ovf", 16'(bus.overflow), 16'h1);
    for (int i = 1; i <= 8; i++) pop_check("t5_drain", 10'(i));
    chk("t5_empty", 16'(bus.rd_valid), 16'h0);
    chk("t5_ovf_sticky", 16'(bus.overflow), 16'h1);
    bus.err_clear = 1'b1;
    @(negedge clk);
    bus.err_clear = 1'b0;
    chk("t5_ovf_clr", 16'(bus.overflow), 16'h0);
    for (int i = 8'h11; i <= 8'h18; i++) send_byte(8'(i), 1'b0);
    chk("t5_refill", 16'(bus.fifo_count), 16'h8);
    ps2_bits(frame_of(8'h19, 1'b0), 11);
    repeat (3) @(negedge clk);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    chk("t5_pp_count", 16'(bus.fifo_count), 16'h8);
    chk("t5_pp_ovf", 16'(bus.overflow), 16'h0);
    chk("t5_pp_head", 16'(bus.rd_data), 16'h012);
    ps2_release();
    for (int i = 8'h12; i <= 8'h19; i++) pop_check("t5_drain2", 10'(i));
    chk("t5_empty2", 16'(bus.rd_valid), 16'h0);

    // 6: reset mid-frame
    send_byte(8'h16, 1'b0);
    chk("t6_pre_count", 16'(bus.fifo_count), 16'h1);
    ps2_bits(frame_of(8'hA5, 1'b0), 5);
    ps2_release();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t6_valid", 16'(bus.rd_valid), 16'h0);
    chk("t6_data", 16'(bus.rd_data), 16'h0);
    chk("t6_count", 16'(bus.fifo_count), 16'h0);
    chk("t6_ovf", 16'(bus.overflow), 16'h0);
    fe_seen = 0;
    for (int i = 0; i < 600; i++) begin
      if (bus.frame_error) fe_seen++;
      @(negedge clk);
    end
    chk("t6_no_ferr", 16'(fe_seen), 16'h0);
    send_byte(8'h5A, 1'b0);
    pop_check("t6_after", 10'h05A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
PS/2 keyboard receiver between the board's keyboard_clock/keyboard_data pins and the CPU's keyboard input port. It synchronises the open-collector PS/2 lines into the CPU clock domain and deframes 11-bit device-to-host frames. It folds E0/F0 prefixes into flag bits and buffers complete scancodes in a small first-word-fall-through FIFO that the CPU drains with a read strobe. Runs entirely on the 16 MHz CPU clock.

Parameters:
TIMEOUT_CYCLES, 32000, idle cycles between PS/2 clock falling edges before a partial frame is aborted (2 ms at 16 MHz)
FIFO_DEPTH, 8, scancode FIFO entries; power of two, minimum 2
SYNC_STAGES, 2, flip-flop stages on each PS/2 input; minimum 2

Ports:
CLK_CPU  input  1  single system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
keyboard_clock  input  1  raw PS/2 clock pin, asynchronous
keyboard_data  input  1  raw PS/2 data pin, asynchronous
rd_en  input  1  pop strobe from CPU; honoured only when rd_valid=1
err_clear  input  1  clears sticky overflow
rd_data  output  10  {extended, break, scancode[7:0]} of FIFO head
rd_valid  output  1  FIFO not empty
fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
frame_error  output  1  one-cycle pulse on parity, start, stop or timeout error
overflow  output  1  sticky; a code was dropped because the FIFO was full

Behaviour:
- Reset (reset=0 at a clock edge): FSM=IDLE, FIFO empty, rd_valid=0, rd_data=0, fifo_count=0, frame_error=0, overflow=0, prefix flags cleared, timeout counter=0. Synchroniser flops preset to 1 (idle bus). Reset mid-frame discards the partial frame and pulses no error.
- Sampling: falling edge = previous synced clock 1, current 0. Data is sampled from the synced data line in the same cycle. All frame logic advances only on falling edges.
- FSM IDLE: on an edge with data=0 go to DATA, bit counter=0. On an edge with data=1 pulse frame_error and stay in IDLE.
- FSM DATA: shift 8 bits LSB first; after the 8th edge go to PARITY.
- FSM PARITY: store the bit; go to STOP.
- FSM STOP: check that the stop bit is 1 and that data plus parity has odd weight. On failure pulse frame_error and clear the prefix flags. On success process the byte. Always return to IDLE.
- Byte processing: 0xE0 sets ext, 0xF0 sets brk, and neither is pushed. Any other byte pushes {ext,brk,byte} and clears both flags. Processing happens in the cycle after the STOP-edge cycle.
- Timeout: the counter clears on every falling edge and in IDLE, and increments otherwise. On reaching TIMEOUT_CYCLES: abort to IDLE, pulse frame_error, clear the prefix flags.
- FIFO push: the write occurs in the processing cycle. rd_valid and updated rd_data are visible the following cycle (2 cycles after the STOP edge when the FIFO was empty).
- FIFO pop: rd_en with rd_valid=1 advances the head, and the new head or rd_valid=0 is visible next cycle. rd_en with rd_valid=0 is ignored.
- Push while full: the new code is dropped and overflow is set. If a pop happens in the same cycle, both the pop and the push succeed and no overflow is flagged.
- Push and pop on a non-empty FIFO in the same cycle leave fifo_count unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- Overflow stays set until err_clear=1, which clears it on the next edge. If an overflow and err_clear coincide, the set wins.
- The FIFO contents are unaffected by frame errors.

Test Plan:
1. Make code: frame 0x1C (start 0, data 0,0,1,1,1,0,0,0, parity 0, stop 1), bench half-period 40 cycles, TIMEOUT_CYCLES=500 -> rd_valid rises 2 cycles after the STOP edge, rd_data=10'h01C, fifo_count=1; rd_en for one cycle -> rd_valid=0 next cycle.
2. Prefix sequences: frames F0,1C then E0,74 then E0,F0,74 -> exactly three entries, read in order 10'h11C, 10'h274, 10'h374; no entries for the prefixes.
3. Parity error: 0x1C sent with parity 1 -> one-cycle frame_error, FIFO unchanged. Then E0 followed by a bad frame followed by 0x74 -> entry 10'h074 (ext cleared by the error).
4. Timeout: clock stops after 5 bits for 600 cycles -> frame_error pulse at exactly cycle 500 after the last edge. A following clean 0x29 -> 10'h029.
5. Overflow: FIFO_DEPTH=8, nine codes 0x01..0x09 with no reads -> fifo_count=8, overflow=1, reads return 0x01..0x08. Then err_clear -> overflow=0. A tenth push coinciding with rd_en while full -> accepted, overflow stays 0.
6. Reset mid-frame: reset=0 for 1 cycle after the 4th data bit -> all outputs zero, no frame_error. The next full frame 0x5A -> 10'h05A.
